// File: rtl/putbits_fifo.sv
// putbits_fifo: bit-stream writer.
// Packs variable-length fields (0..24 bits, MSB first) into 64-bit words for the
// downstream video fifo. Supports byte alignment and an end-of-stream flush.
// Optional build macro PUTBITS_COUNT_EN adds a running bit_count output.
module putbits_fifo (
    input  logic        clk,
    input  logic        clk_en,
    input  logic        rst,
    input  logic [23:0] putbits,
    input  logic [4:0]  len,
    input  logic        put_valid,
    input  logic        align,
    input  logic        flush,
    output logic        put_ready,
    output logic        flush_done,
    output logic [63:0] vid_out,
    output logic        vid_out_wr_en,
`ifdef PUTBITS_COUNT_EN
    output logic [31:0] bit_count,
`endif
    input  logic        vid_out_wr_almost_full
);

    typedef enum logic [1:0] {
        StReady,
        StFlush2,
        StFlush
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [6:0]  fill_q, fill_d;
    logic [63:0] vid_out_q, vid_out_d;
    logic        wr_en_q, wr_en_d;
`ifdef PUTBITS_COUNT_EN
    logic [31:0] count_q, count_d;
`endif

    logic [4:0]   len_eff;
    logic [23:0]  field_mask;
    logic [23:0]  field_lj;
    logic [127:0] wide;
    logic [6:0]   sum;
    logic [6:0]   fill_v;
    logic [63:0]  acc_v;
    logic [6:0]   pad;
    logic         emitted;

    // Field preparation: clamp length, mask, left-justify and place after pending bits.
    always_comb begin
        len_eff    = (len > 5'd24) ? 5'd24 : len;
        field_mask = 24'hFF_FFFF >> (5'd24 - len_eff);
        field_lj   = (putbits & field_mask) << (5'd24 - len_eff);
        // acc occupies the top 64 bits; the field spills into the low half when it crosses 64.
        wide       = {acc_q, 64'b0} | ({field_lj, 104'b0} >> fill_q);
        sum        = fill_q + {2'b0, len_eff};
    end

    assign put_ready     = rst && (state_q == StReady) && !vid_out_wr_almost_full;
    assign flush_done    = (state_q == StFlush);
    assign vid_out       = vid_out_q;
    assign vid_out_wr_en = wr_en_q;
`ifdef PUTBITS_COUNT_EN
    assign bit_count     = count_q;
`endif

    // Next state: field write, then align, then flush, with at most one word per cycle.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        fill_d    = fill_q;
        vid_out_d = vid_out_q;
        wr_en_d   = 1'b0;
`ifdef PUTBITS_COUNT_EN
        count_d   = count_q;
`endif
        acc_v     = acc_q;
        fill_v    = fill_q;
        pad       = 7'd0;
        emitted   = 1'b0;

        unique case (state_q)
            StReady: begin
                if (put_ready) begin
                    if (put_valid && (len_eff != 5'd0)) begin
`ifdef PUTBITS_COUNT_EN
                        count_d = count_d + {27'b0, len_eff};
`endif
                        if (sum[6]) begin
                            vid_out_d = wide[127:64];
                            wr_en_d   = 1'b1;
                            emitted   = 1'b1;
                            acc_v     = wide[63:0];
                            fill_v    = sum - 7'd64;
                        end else begin
                            acc_v  = wide[127:64];
                            fill_v = sum;
                        end
                    end
                    // After a word completes fill is at most 23, so align cannot emit twice.
                    if (align && (fill_v[2:0] != 3'd0)) begin
                        pad    = 7'd8 - {4'd0, fill_v[2:0]};
                        fill_v = fill_v + pad;
`ifdef PUTBITS_COUNT_EN
                        count_d = count_d + {25'b0, pad};
`endif
                        if (fill_v == 7'd64) begin
                            vid_out_d = acc_v;
                            wr_en_d   = 1'b1;
                            emitted   = 1'b1;
                            acc_v     = 64'b0;
                            fill_v    = 7'd0;
                        end
                    end
                    if (flush) begin
                        state_d = StFlush;
                        if (fill_v != 7'd0) begin
`ifdef PUTBITS_COUNT_EN
                            count_d = count_d + {25'b0, 7'd64 - fill_v};
`endif
                            if (emitted) begin
                                // Output register busy this cycle; emit remainder next cycle.
                                state_d = StFlush2;
                            end else begin
                                vid_out_d = acc_v;
                                wr_en_d   = 1'b1;
                                acc_v     = 64'b0;
                                fill_v    = 7'd0;
                            end
                        end
                    end
                    acc_d  = acc_v;
                    fill_d = fill_v;
                end
            end
            StFlush2: begin
                vid_out_d = acc_q;
                wr_en_d   = 1'b1;
                acc_d     = 64'b0;
                fill_d    = 7'd0;
                state_d   = StFlush;
            end
            StFlush: begin
                state_d = StReady;
            end
            default: begin
                state_d = StReady;
            end
        endcase
    end

    // State registers: synchronous active-low reset, hold while clk_en is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StReady;
            acc_q     <= 64'b0;
            fill_q    <= 7'd0;
            vid_out_q <= 64'b0;
            wr_en_q   <= 1'b0;
`ifdef PUTBITS_COUNT_EN
            count_q   <= 32'd0;
`endif
        end else if (clk_en) begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            fill_q    <= fill_d;
            vid_out_q <= vid_out_d;
            wr_en_q   <= wr_en_d;
`ifdef PUTBITS_COUNT_EN
            count_q   <= count_d;
`endif
        end
    end

endmodule

// File: tb/tb_putbits_fifo.sv
// Directed bench for putbits_fifo with hand-computed expected words.
module tb_putbits_fifo;

    logic        clk = 1'b0;
    logic        clk_en;
    logic        rst;
    logic [23:0] putbits;
    logic [4:0]  len;
    logic        put_valid;
    logic        align;
    logic        flush;
    logic        put_ready;
    logic        flush_done;
    logic [63:0] vid_out;
    logic        vid_out_wr_en;
    logic        almost_full;
`ifdef PUTBITS_COUNT_EN
    logic [31:0] bit_count;
`endif

    int total = 0;
    int bad   = 0;

    putbits_fifo dut (
        .clk                    (clk),
        .clk_en                 (clk_en),
        .rst                    (rst),
        .putbits                (putbits),
        .len                    (len),
        .put_valid              (put_valid),
        .align                  (align),
        .flush                  (flush),
        .put_ready              (put_ready),
        .flush_done             (flush_done),
        .vid_out                (vid_out),
        .vid_out_wr_en          (vid_out_wr_en),
`ifdef PUTBITS_COUNT_EN
        .bit_count              (bit_count),
`endif
        .vid_out_wr_almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One enabled cycle carrying a field and optional align/flush.
    task automatic put(input logic [23:0] b, input logic [4:0] l, input logic a,
                       input logic f);
        putbits   = b;
        len       = l;
        put_valid = 1'b1;
        align     = a;
        flush     = f;
        cyc();
        put_valid = 1'b0;
        align     = 1'b0;
        flush     = 1'b0;
        len       = 5'd0;
        putbits   = 24'd0;
    endtask

    logic [7:0] bytes [8] = '{8'h00, 8'h00, 8'h01, 8'hB3, 8'h16, 8'h00, 8'hF0, 8'h15};

    initial begin
        clk_en      = 1'b1;
        rst         = 1'b0;
        putbits     = 24'd0;
        len         = 5'd0;
        put_valid   = 1'b0;
        align       = 1'b0;
        flush       = 1'b0;
        almost_full = 1'b0;

        // Reset values
        cyc();
        cyc();
        chk("rst_ready", put_ready, 0);
        chk("rst_vid", vid_out, 0);
        chk("rst_wr", vid_out_wr_en, 0);
        chk("rst_done", flush_done, 0);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", put_ready, 1);

        // Eight bytes complete one word
        for (int i = 0; i < 8; i++) begin
            put({16'd0, bytes[i]}, 5'd8, 1'b0, 1'b0);
            if (i == 6) chk("bytes_no_wr", vid_out_wr_en, 0);
        end
        chk("bytes_wr", vid_out_wr_en, 1);
        chk("bytes_word", vid_out, 64'h000001B31600F015);
        cyc();
        chk("bytes_wr_drop", vid_out_wr_en, 0);
`ifdef PUTBITS_COUNT_EN
        chk("bit_count", {32'd0, bit_count}, 64);
`endif

        // fill=60 then a 24-bit field crosses the word boundary
        put(24'h123456, 5'd24, 1'b0, 1'b0);
        put(24'h789ABC, 5'd24, 1'b0, 1'b0);
        put(24'h000DEF, 5'd12, 1'b0, 1'b0);
        chk("f60_no_wr", vid_out_wr_en, 0);
        put(24'hABCDEF, 5'd24, 1'b0, 1'b0);
        chk("cross_wr", vid_out_wr_en, 1);
        chk("cross_word", vid_out, 64'h123456789ABCDEFA);
        put(24'd0, 5'd0, 1'b0, 1'b1);
        chk("rem_wr", vid_out_wr_en, 1);
        chk("rem_word", vid_out, 64'hBCDEF00000000000);
        chk("rem_done", flush_done, 1);
        chk("rem_busy", put_ready, 0);
        cyc();
        chk("rem_done_drop", flush_done, 0);
        chk("rem_ready", put_ready, 1);

        // Align pads to a byte once; a second align is a no-op
        put(24'h000005, 5'd3, 1'b0, 1'b0);
        put(24'd0, 5'd0, 1'b1, 1'b0);
        chk("align1_no_wr", vid_out_wr_en, 0);
        put(24'd0, 5'd0, 1'b1, 1'b0);
        chk("align2_no_wr", vid_out_wr_en, 0);
        put(24'h111111, 5'd24, 1'b0, 1'b0);
        put(24'h222222, 5'd24, 1'b0, 1'b0);
        chk("align_fill8", vid_out_wr_en, 0);
        put(24'h000033, 5'd8, 1'b0, 1'b0);
        chk("align_wr", vid_out_wr_en, 1);
        chk("align_word", vid_out, 64'hA011111122222233);

        // Flush with data, then flush with nothing pending
        put(24'h000FFF, 5'd12, 1'b0, 1'b1);
        chk("flush_wr", vid_out_wr_en, 1);
        chk("flush_word", vid_out, 64'hFFF0000000000000);
        chk("flush_done", flush_done, 1);
        cyc();
        chk("flush_done_drop", flush_done, 0);
        put(24'd0, 5'd0, 1'b0, 1'b1);
        chk("empty_flush_no_wr", vid_out_wr_en, 0);
        chk("empty_flush_done", flush_done, 1);
        cyc();

        // Align reaching 64 emits the word
        put(24'h123456, 5'd24, 1'b0, 1'b0);
        put(24'h789ABC, 5'd24, 1'b0, 1'b0);
        put(24'h000DEF, 5'd12, 1'b1, 1'b0);
        chk("align64_wr", vid_out_wr_en, 1);
        chk("align64_word", vid_out, 64'h123456789ABCDEF0);
        put(24'd0, 5'd0, 1'b0, 1'b1);
        chk("align64_fill0", vid_out_wr_en, 0);
        cyc();

        // Field + flush with remainder: two words, len above 24 clamps to 24
        put(24'h123456, 5'd31, 1'b0, 1'b0);
        put(24'h789ABC, 5'd24, 1'b0, 1'b0);
        put(24'h000DEF, 5'd12, 1'b0, 1'b0);
        put(24'hABCDEF, 5'd24, 1'b0, 1'b1);
        chk("f2_wr1", vid_out_wr_en, 1);
        chk("f2_word1", vid_out, 64'h123456789ABCDEFA);
        chk("f2_done_early", flush_done, 0);
        chk("f2_busy", put_ready, 0);
        cyc();
        chk("f2_wr2", vid_out_wr_en, 1);
        chk("f2_word2", vid_out, 64'hBCDEF00000000000);
        chk("f2_done", flush_done, 1);
        cyc();
        chk("f2_done_drop", flush_done, 0);
        chk("f2_ready", put_ready, 1);
        chk("f2_wr_drop", vid_out_wr_en, 0);

        // Almost-full blocks acceptance; release accepts the held field
        almost_full = 1'b1;
        putbits     = 24'h00005A;
        len         = 5'd8;
        put_valid   = 1'b1;
        #1;
        chk("af_ready", put_ready, 0);
        cyc();
        cyc();
        chk("af_no_wr", vid_out_wr_en, 0);
        almost_full = 1'b0;
        #1;
        chk("af_release_ready", put_ready, 1);
        cyc();
        put_valid = 1'b0;
        put(24'd0, 5'd0, 1'b0, 1'b1);
        chk("af_wr", vid_out_wr_en, 1);
        chk("af_word", vid_out, 64'h5A00000000000000);
        cyc();

        // clk_en low freezes everything, including a strobe in flight
        put(24'h111111, 5'd24, 1'b0, 1'b0);
        put(24'h222222, 5'd24, 1'b0, 1'b0);
        put(24'h000033, 5'd8, 1'b0, 1'b0);
        put(24'h000077, 5'd8, 1'b0, 1'b0);
        chk("ce_wr", vid_out_wr_en, 1);
        chk("ce_word", vid_out, 64'h1111112222223377);
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            putbits   = 24'($urandom);
            len       = 5'd8;
            put_valid = 1'b1;
            flush     = i[0];
            align     = ~i[0];
            cyc();
        end
        chk("ce_wr_frozen", vid_out_wr_en, 1);
        chk("ce_word_frozen", vid_out, 64'h1111112222223377);
        chk("ce_done_frozen", flush_done, 0);
        put_valid = 1'b0;
        flush     = 1'b0;
        align     = 1'b0;
        len       = 5'd0;
        clk_en    = 1'b1;
        cyc();
        chk("ce_wr_drop", vid_out_wr_en, 0);
        put(24'd0, 5'd0, 1'b0, 1'b1);
        chk("ce_fill0", vid_out_wr_en, 0);
        chk("ce_flush_done", flush_done, 1);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
